// File: rtl/zb_fifo_pkg.sv
// zb_fifo_pkg: sizing helpers and parameter sanity checks for the FIFO.
package zb_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int t, input int depth);
        return (t >= 1) && (t <= depth - 1);
    endfunction

endpackage

// File: rtl/zb_fifo_ram.sv
// zb_fifo_ram: DEPTH x DATA_WIDTH storage, sync write, sync registered read.
module zb_fifo_ram
    import zb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int AW         = ptr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read-before-write when both ports hit the same address.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/zb_param_fifo.sv
// zb_param_fifo: parametrised sync FIFO with level, thresholds, sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module zb_param_fifo
    import zb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 4,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                    inClock,
    input  logic                    inReset,
    input  logic                    inClear,
    input  logic                    inWriteEnable,
    input  logic [DATA_WIDTH-1:0]   inData,
    input  logic                    inReadEnable,
    output logic [DATA_WIDTH-1:0]   outData,
    output logic                    outValid,
    output logic                    outFull,
    output logic                    outEmpty,
    output logic                    outAlmostFull,
    output logic                    outAlmostEmpty,
    output logic [$clog2(DEPTH):0]  outLevel,
    output logic                    outOverflow,
    output logic                    outUnderflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = level_width(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [LW-1:0] level_t;

    localparam level_t LVL_FULL = level_t'(DEPTH);
    localparam level_t LVL_AF   = level_t'(AFULL_THRESH);
    localparam level_t LVL_AE   = level_t'(AEMPTY_THRESH);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_chk_depth
        $error("zb_param_fifo: DEPTH must be a power of 2 and >= 4");
    end
    if (!thresh_ok(AFULL_THRESH, DEPTH) || !thresh_ok(AEMPTY_THRESH, DEPTH)) begin : g_chk_thr
        $error("zb_param_fifo: thresholds must lie in 1..DEPTH-1");
    end
    if (DATA_WIDTH < 1) begin : g_chk_dw
        $error("zb_param_fifo: DATA_WIDTH must be >= 1");
    end

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    level_t level_q, level_d;
    logic   full_q, empty_q, afull_q, aempty_q;
    logic   ovf_q, udf_q, valid_q;
    logic   wr_acc, rd_acc, ram_we, ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign wr_acc = inWriteEnable & (~full_q | rd_acc);
    assign ram_we = wr_acc & ~inClear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (inClear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (ram_re) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Flags track the next level so they line up with outLevel.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LVL_FULL);
            empty_q  <= (level_d == '0);
            afull_q  <= (level_d >= LVL_AF);
            aempty_q <= (level_d <= LVL_AE);
            if (inClear) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end else begin
                if (inWriteEnable & ~wr_acc) ovf_q <= 1'b1;
                if (inReadEnable & ~rd_acc) udf_q <= 1'b1;
            end
        end
    end

    zb_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk_i   (inClock),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (inData),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

`ifdef FIFO_FWFT_EN
    // RAM read register acts as a prefetch stage ahead of the output word.
    level_t ram_cnt_q, ram_cnt_d;
    logic   mid_vld_q, mid_move;
    logic [DATA_WIDTH-1:0] out_data_q;

    assign rd_acc   = inReadEnable & valid_q;
    assign mid_move = mid_vld_q & (~valid_q | rd_acc);
    assign ram_re   = (ram_cnt_q != '0) & (~mid_vld_q | mid_move) & ~inClear;

    always_comb begin
        ram_cnt_d = ram_cnt_q;
        unique case ({ram_we, ram_re})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            ram_cnt_q  <= '0;
            mid_vld_q  <= 1'b0;
            valid_q    <= 1'b0;
            out_data_q <= '0;
        end else if (inClear) begin
            ram_cnt_q <= '0;
            mid_vld_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            ram_cnt_q <= ram_cnt_d;
            mid_vld_q <= ram_re | (mid_vld_q & ~mid_move);
            valid_q   <= mid_move | (valid_q & ~rd_acc);
            if (mid_move) out_data_q <= ram_rdata;
        end
    end

    assign outData = out_data_q;
`else
    logic seen_q;

    assign rd_acc = inReadEnable & ~empty_q;
    assign ram_re = rd_acc & ~inClear;

    // RAM read register holds between reads; mask it until first read.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            valid_q <= ram_re;
            if (ram_re) seen_q <= 1'b1;
        end
    end

    assign outData = seen_q ? ram_rdata : '0;
`endif

    assign outValid       = valid_q;
    assign outFull        = full_q;
    assign outEmpty       = empty_q;
    assign outAlmostFull  = afull_q;
    assign outAlmostEmpty = aempty_q;
    assign outLevel       = level_q;
    assign outOverflow    = ovf_q;
    assign outUnderflow   = udf_q;

endmodule

// File: tb/tb_zb_param_fifo.sv
// tb_zb_param_fifo: directed stimulus with a queue-based read-data scoreboard.
// Covers reset, fill/drain, wrap, boundaries, flush and mid-run reset.
module tb_zb_param_fifo;

    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dout;
    logic          vld, full, empty, afull, aempty, ovf, udf;
    logic [3:0]    lvl;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_w;

    zb_param_fifo #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .inClock        (clk),
        .inReset        (rst),
        .inClear        (clr),
        .inWriteEnable  (we),
        .inData         (din),
        .inReadEnable   (re),
        .outData        (dout),
        .outValid       (vld),
        .outFull        (full),
        .outEmpty       (empty),
        .outAlmostFull  (afull),
        .outAlmostEmpty (aempty),
        .outLevel       (lvl),
        .outOverflow    (ovf),
        .outUnderflow   (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        we  = w;
        din = d;
        re  = r;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic rd_exp(input logic [DW-1:0] v);
        exp_q.push_back(v);
        cyc(1'b0, '0, 1'b1);
    endtask

    // Monitor: a word leaves the FIFO when the output handshake fires.
    always @(negedge clk) begin
        if (!rst) begin
`ifdef FIFO_FWFT_EN
            if (vld && re) begin
`else
            if (vld) begin
`endif
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0h, required none", dout);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("read_data", 32'(dout), 32'(exp_w));
                end
            end
        end
    end

    initial begin
        // Reset
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_empty",  32'(empty),  1);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_level",  32'(lvl),    0);
        chk("rst_valid",  32'(vld),    0);
        chk("rst_full",   32'(full),   0);
        chk("rst_afull",  32'(afull),  0);
        chk("rst_ovf",    32'(ovf),    0);
        chk("rst_udf",    32'(udf),    0);
        chk("rst_data",   32'(dout),   0);

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 4'(i + 1), 1'b0);
            chk("fill_level",  32'(lvl),    i + 1);
            chk("fill_afull",  32'(afull),  ((i + 1) >= AF) ? 1 : 0);
            chk("fill_aempty", 32'(aempty), ((i + 1) <= AE) ? 1 : 0);
`ifdef FIFO_FWFT_EN
            chk("fwft_valid", 32'(vld), (i >= 2) ? 1 : 0);
            if (i >= 2) chk("fwft_head", 32'(dout), 1);
`endif
        end
        chk("fill_full",  32'(full),  1);
        chk("fill_empty", 32'(empty), 0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_exp(4'(i + 1));
            chk("drain_level", 32'(lvl), DEPTH - 1 - i);
        end
        chk("drain_empty",  32'(empty),  1);
        chk("drain_full",   32'(full),   0);
        chk("drain_aempty", 32'(aempty), 1);

        // Pointer wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) cyc(1'b1, 4'(10 + i), 1'b0);
            chk("wrap_level", 32'(lvl), 5);
            for (int i = 0; i < 5; i++) rd_exp(4'(10 + i));
        end
        chk("wrap_ovf",   32'(ovf),   0);
        chk("wrap_udf",   32'(udf),   0);
        chk("wrap_empty", 32'(empty), 1);

`ifndef FIFO_FWFT_EN
        // Boundaries
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(i), 1'b0);
        cyc(1'b1, 4'hF, 1'b0);
        chk("ovf_set",   32'(ovf),  1);
        chk("ovf_level", 32'(lvl),  8);
        chk("ovf_full",  32'(full), 1);
        exp_q.push_back(4'h0);
        cyc(1'b1, 4'h9, 1'b1);
        chk("full_rdwr_level", 32'(lvl),  8);
        chk("full_rdwr_full",  32'(full), 1);
        for (int i = 1; i < DEPTH; i++) rd_exp(4'(i));
        rd_exp(4'h9);
        chk("bnd_empty", 32'(empty), 1);
        chk("bnd_udf0",  32'(udf),   0);
        cyc(1'b0, '0, 1'b1);
        chk("udf_set",   32'(udf), 1);
        chk("udf_level", 32'(lvl), 0);
        cyc(1'b1, 4'hC, 1'b1);
        chk("empty_rdwr_level", 32'(lvl),   1);
        chk("empty_rdwr_empty", 32'(empty), 0);
        rd_exp(4'hC);
        chk("rd_lat_valid", 32'(vld),  1);
        chk("rd_lat_data",  32'(dout), 12);

        // Flush with a concurrent write
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 1), 1'b0);
        chk("pre_flush_level", 32'(lvl), 5);
        chk("pre_flush_ovf",   32'(ovf), 1);
        clr = 1'b1;
        cyc(1'b1, 4'h6, 1'b0);
        clr = 1'b0;
        chk("flush_level",  32'(lvl),    0);
        chk("flush_empty",  32'(empty),  1);
        chk("flush_aempty", 32'(aempty), 1);
        chk("flush_ovf",    32'(ovf),    0);
        chk("flush_udf",    32'(udf),    0);
        chk("flush_valid",  32'(vld),    0);
        chk("flush_hold",   32'(dout),   12);
        cyc(1'b1, 4'h7, 1'b0);
        chk("post_flush_level", 32'(lvl), 1);
        rd_exp(4'h7);

        // Asynchronous reset in the middle of a read
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 1), 1'b0);
        chk("pre_rst_level", 32'(lvl), 3);
        re = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_level",  32'(lvl),    0);
        chk("mid_rst_empty",  32'(empty),  1);
        chk("mid_rst_aempty", 32'(aempty), 1);
        chk("mid_rst_full",   32'(full),   0);
        chk("mid_rst_valid",  32'(vld),    0);
        chk("mid_rst_data",   32'(dout),   0);
        @(posedge clk);
        #1;
        re  = 1'b0;
        rst = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
